pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register that replaces the fixed per-stage latch (IR/ALU result/DM data/PC+4/PC+8) between CPU stages. It carries NUM_FIELDS packed fields of DATA_W bits with a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, and a synchronous flush that inserts a bubble. One instance sits between each pair of pipeline stages (F/D, D/E, E/M, M/W).

Parameters:
DATA_W, 32, width of one field in bits
NUM_FIELDS, 5, number of fields; the bus is NUM_FIELDS*DATA_W bits, field k at bits [k*DATA_W +: DATA_W]
FLUSH_VAL, 0, DATA_W-bit value loaded into every field on reset and flush (0 = nop encoding)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream stage presents a beat
in_ready  out  1  block accepts a beat this cycle; registered
in_data  in  NUM_FIELDS*DATA_W  upstream fields
flush  in  1  synchronous bubble insert (branch/exception kill)
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  downstream stage accepts the beat
out_data  out  NUM_FIELDS*DATA_W  downstream fields; registered

Behaviour:
- State: main entry (main_v, main_d) drives out_valid/out_data; skid entry (skid_v, skid_d) is internal.
- Reset (async, immediate): main_v=0, skid_v=0, in_ready=1, out_valid=0, all out_data fields=FLUSH_VAL, skid_d=FLUSH_VAL replicated.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~skid_v, registered (next value = ~next skid_v).
- Latency 1 cycle from in_fire to out_valid; throughput 1 beat/cycle while out_ready=1.
- Per-edge update (flush not asserted):
  - main empty, in_fire: main <= in_data, main_v <= 1.
  - main full, out_fire, skid_v=1: main <= skid, skid_v <= 0 (no in_fire possible).
  - main full, out_fire, skid_v=0, in_fire: main <= in_data.
  - main full, out_fire, no in_fire: main_v <= 0; main_d holds last value.
  - main full, no out_fire, in_fire: skid <= in_data, skid_v <= 1; in_ready falls next cycle.
  - otherwise hold.
- out_data and out_valid stay stable while out_valid & ~out_ready.
- Beat order is strictly FIFO; no beat duplicated or dropped except by flush.
- Flush (highest priority, synchronous): main_v <= 0, skid_v <= 0, in_ready <= 1, all main and skid fields <= FLUSH_VAL. A beat presented on in_* that cycle is discarded even if in_ready=1. A beat on out_* that cycle counts as delivered if out_ready=1.
- Reset asserted mid-transfer overrides everything; no beat survives.

Optional Feature:
PIPE_STAGE_PERF_CNT_EN: when defined, adds outputs stall_cnt[31:0] (cycles with out_valid & ~out_ready) and beat_cnt[31:0] (out_fire count). Both reset to 0 on reset only (not flush) and wrap modulo 2^32. When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Async reset: DATA_W=32, NUM_FIELDS=5, two beats held, assert reset between edges -> out_valid=0, in_ready=1, out_data=160'h0 before the next edge.
- Streaming: out_ready=1, in_valid=1, field0 = 1..8 on consecutive cycles -> out_valid=1 from cycle 1, field0 = 1..8 in order with no gaps, in_ready constantly 1.
- Backpressure: out_ready=0, push A=0x11, B=0x22 -> in_ready=0 after B; C=0x33 held upstream; out_data stays A. Raise out_ready -> outputs A, B, C on successive cycles.
- Flush with full skid: main=A, skid=B, flush=1, in_valid=1 with 0x44 -> next cycle out_valid=0, in_ready=1, every field=FLUSH_VAL; 0x44 never appears.
- Flush with out_fire: main=A, out_ready=1, flush=1 -> A counted as delivered (beat_cnt+1 when the feature is enabled); next cycle out_valid=0.
- Perf counters (PIPE_STAGE_PERF_CNT_EN): 3 stall cycles then 4 beats -> stall_cnt=3, beat_cnt=4; counters preloaded to 0xFFFFFFFF wrap to 0 on the next event.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register with 2-entry skid buffer and flush
// Optional macro PIPE_STAGE_PERF_CNT_EN adds stall_cnt/beat_cnt performance counters.
module pipe_stage_reg #(
    parameter int              DATA_W     = 32,
    parameter int              NUM_FIELDS = 5,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  beat_cnt
`endif
);

    localparam int BUS_W = NUM_FIELDS * DATA_W;
    localparam logic [BUS_W-1:0] FLUSH_BUS = {NUM_FIELDS{FLUSH_VAL}};

    logic             main_v, main_v_n;
    logic [BUS_W-1:0] main_d, main_d_n;
    logic             skid_v, skid_v_n;
    logic [BUS_W-1:0] skid_d, skid_d_n;
    logic             in_fire, out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;

    // skid_v implies main_v, so an empty main never needs to drain the skid entry
    always_comb begin
        main_v_n = main_v;
        main_d_n = main_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
            main_d_n = FLUSH_BUS;
            skid_d_n = FLUSH_BUS;
        end else if (!main_v) begin
            if (in_fire) begin
                main_d_n = in_data;
                main_v_n = 1'b1;
            end
        end else if (out_fire) begin
            if (skid_v) begin
                main_d_n = skid_d;
                skid_v_n = 1'b0;
            end else if (in_fire) begin
                main_d_n = in_data;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_d_n = in_data;
            skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_d   <= FLUSH_BUS;
            skid_d   <= FLUSH_BUS;
            in_ready <= 1'b1;
        end else begin
            main_v   <= main_v_n;
            skid_v   <= skid_v_n;
            main_d   <= main_d_n;
            skid_d   <= skid_d_n;
            in_ready <= ~skid_v_n;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    // counters survive flush; only reset clears them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (main_v && !out_ready) stall_cnt <= stall_cnt + 32'd1;
            if (out_fire)             beat_cnt  <= beat_cnt + 32'd1;
        end
    end
`endif

endmodule
